// File: rtl/counter_chk_pkg.sv
// Shared types and the reference counting rule for the loadable-counter checker.
package counter_chk_pkg;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Load beats enable; enable increments modulo 2^width; otherwise hold.
  function automatic logic [31:0] next_count(input logic        ld,
                                             input logic        en,
                                             input logic [31:0] dat,
                                             input logic [31:0] cnt,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    if (ld)      next_count = dat & mask;
    else if (en) next_count = (cnt + 32'd1) & mask;
    else         next_count = cnt & mask;
  endfunction

endpackage

// File: rtl/counter_checker_if.sv
// Observed port set of the loadable counter; the checker only listens.
interface counter_checker_if #(
  parameter int unsigned WIDTH = counter_chk_pkg::DEF_WIDTH
);
  logic             enable_i;
  logic             load_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] count_o;

  modport master (output enable_i, load_i, data_i, count_o);
  modport slave  (input  enable_i, load_i, data_i, count_o);
endinterface

// File: rtl/counter_ref_model.sv
// One-cycle-delayed copy of the counter's inputs/output and the predicted next count.
module counter_ref_model
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  counter_checker_if.slave    mon,
  output logic [WIDTH-1:0]    exp_c
);

  logic [WIDTH-1:0] prev_cnt;
  logic [WIDTH-1:0] prev_dat;
  logic             prev_en;
  logic             prev_ld;

  // Reseeded from the observed count every cycle so one error never cascades.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_cnt <= '0;
      prev_dat <= '0;
      prev_en  <= 1'b0;
      prev_ld  <= 1'b0;
    end else begin
      prev_cnt <= mon.count_o;
      prev_dat <= mon.data_i;
      prev_en  <= mon.enable_i;
      prev_ld  <= mon.load_i;
    end
  end

  always_comb begin
    exp_c = WIDTH'(next_count(prev_ld, prev_en, 32'(prev_dat), 32'(prev_cnt), WIDTH));
  end

endmodule

// File: rtl/counter_checker.sv
// Scoreboard for a loadable counter: predicts each count, flags and logs mismatches.
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W   = DEF_ERR_CNT_W,
  parameter bit          HALT_ON_ERR = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 check_en_i,
  input  logic                 clear_i,
  counter_checker_if.slave     mon,
  output logic                 err_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [WIDTH-1:0]     first_exp_o,
  output logic [WIDTH-1:0]     first_act_o,
  output logic                 checking_o
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] exp_c;
  logic             mismatch_c;
  logic             err_event_c;

  counter_ref_model #(.WIDTH(WIDTH)) u_ref_model (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mon   (mon),
    .exp_c (exp_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Dropping check_en_i returns to IDLE from anywhere, so re-enabling always resyncs.
  always_comb begin
    state_next = state;
    if (!check_en_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = SYNC;
        SYNC:    state_next = CHECK;
        CHECK:   if (err_event_c && HALT_ON_ERR) state_next = HALT;
        HALT:    if (clear_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A clear on the same edge as a mismatch wins.
  always_comb begin
    mismatch_c  = 1'b0;
    err_event_c = 1'b0;
    if (state == CHECK && check_en_i) mismatch_c = (mon.count_o != exp_c);
    err_event_c = mismatch_c && !clear_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
      err_count_o  <= '0;
      first_exp_o  <= '0;
      first_act_o  <= '0;
      checking_o   <= 1'b0;
    end else begin
      err_o      <= err_event_c;
      checking_o <= (state_next == CHECK);
      if (clear_i) begin
        err_sticky_o <= 1'b0;
        err_count_o  <= '0;
        first_exp_o  <= '0;
        first_act_o  <= '0;
      end else if (err_event_c) begin
        if (err_count_o != '1) err_count_o <= err_count_o + ERR_CNT_W'(1);
        if (!err_sticky_o) begin
          err_sticky_o <= 1'b1;
          first_exp_o  <= exp_c;
          first_act_o  <= mon.count_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench: three checker builds (default, 2-bit error counter, halt-on-error) share one stimulus.
module tb_counter_checker;

  logic clk = 1'b0;
  logic rst;
  logic check_en;
  logic clear;

  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(4)) bus ();

  logic       d_err, d_sticky, d_checking;
  logic [7:0] d_count;
  logic [3:0] d_fexp, d_fact;
  logic       s_err, s_sticky, s_checking;
  logic [1:0] s_count;
  logic [3:0] s_fexp, s_fact;
  logic       h_err, h_sticky, h_checking;
  logic [7:0] h_count;
  logic [3:0] h_fexp, h_fact;

  counter_checker #(.WIDTH(4), .ERR_CNT_W(8), .HALT_ON_ERR(1'b0)) u_dflt (
    .clk_i(clk), .rst_i(rst), .check_en_i(check_en), .clear_i(clear), .mon(bus),
    .err_o(d_err), .err_sticky_o(d_sticky), .err_count_o(d_count),
    .first_exp_o(d_fexp), .first_act_o(d_fact), .checking_o(d_checking));

  counter_checker #(.WIDTH(4), .ERR_CNT_W(2), .HALT_ON_ERR(1'b0)) u_sat (
    .clk_i(clk), .rst_i(rst), .check_en_i(check_en), .clear_i(clear), .mon(bus),
    .err_o(s_err), .err_sticky_o(s_sticky), .err_count_o(s_count),
    .first_exp_o(s_fexp), .first_act_o(s_fact), .checking_o(s_checking));

  counter_checker #(.WIDTH(4), .ERR_CNT_W(8), .HALT_ON_ERR(1'b1)) u_halt (
    .clk_i(clk), .rst_i(rst), .check_en_i(check_en), .clear_i(clear), .mon(bus),
    .err_o(h_err), .err_sticky_o(h_sticky), .err_count_o(h_count),
    .first_exp_o(h_fexp), .first_act_o(h_fact), .checking_o(h_checking));

  int checks = 0;
  int failures = 0;

  // Behaviour of a correct counter, seeded from whatever was last shown on count_o.
  logic [3:0] prev_drv = 4'd0;
  logic [3:0] prev_dat = 4'd0;
  logic       prev_en  = 1'b0;
  logic       prev_ld  = 1'b0;
  logic [3:0] exp_now;

  localparam logic [1:0] S_EXP [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  // Called at a negedge: present count_o (correct value xor mask) and new inputs, run one edge.
  task automatic cyc(input logic en, input logic ld, input logic [3:0] dat, input logic [3:0] mask);
    exp_now      = prev_ld ? prev_dat : (prev_en ? prev_drv + 4'd1 : prev_drv);
    bus.count_o  = exp_now ^ mask;
    bus.enable_i = en;
    bus.load_i   = ld;
    bus.data_i   = dat;
    prev_drv = exp_now ^ mask;
    prev_en  = en;
    prev_ld  = ld;
    prev_dat = dat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; check_en = 1'b0; clear = 1'b0;
    bus.enable_i = 1'b0; bus.load_i = 1'b0; bus.data_i = 4'd0; bus.count_o = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_err, d_sticky, d_count, d_fexp, d_fact, d_checking} !== 19'd0) begin
      failures++;
      $display("FAIL reset_dflt got=%0h exp=0", {d_err, d_sticky, d_count, d_fexp, d_fact, d_checking});
    end
    checks++;
    if ({h_err, h_sticky, h_count, h_checking, s_count} !== 13'd0) begin
      failures++;
      $display("FAIL reset_halt_sat got=%0h exp=0", {h_err, h_sticky, h_count, h_checking, s_count});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_counting();
    check_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b0, 4'd0, 4'd0);
      checks++;
      if (d_err !== 1'b0) begin
        failures++;
        $display("FAIL count_err cyc=%0d got=%0b exp=0", i, d_err);
      end
      checks++;
      if (d_checking !== (i >= 2)) begin
        failures++;
        $display("FAIL count_checking cyc=%0d got=%0b exp=%0b", i, d_checking, (i >= 2));
      end
    end
    checks++;
    if ({d_count, d_sticky, h_count} !== 17'd0) begin
      failures++;
      $display("FAIL count_total got=%0h exp=0", {d_count, d_sticky, h_count});
    end
  endtask

  task automatic test_load_priority();
    cyc(1'b1, 1'b1, 4'd9, 4'd0);
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    checks++;
    if (bus.count_o !== 4'd9 || d_err !== 1'b0 || d_count !== 8'd0) begin
      failures++;
      $display("FAIL load_ok count=%0d err=%0b errs=%0d exp count=9 err=0 errs=0", bus.count_o, d_err, d_count);
    end
  endtask

  task automatic test_mismatch();
    cyc(1'b1, 1'b1, 4'd9, 4'd0);
    cyc(1'b0, 1'b0, 4'd0, 4'h3);
    checks++;
    if ({d_err, d_sticky, d_count, d_fexp, d_fact} !== {1'b1, 1'b1, 8'd1, 4'd9, 4'd10}) begin
      failures++;
      $display("FAIL mismatch_capture got err=%0b sticky=%0b cnt=%0d fexp=%0d fact=%0d exp 1 1 1 9 10",
               d_err, d_sticky, d_count, d_fexp, d_fact);
    end
    checks++;
    if ({h_checking, h_count, s_count} !== {1'b0, 8'd1, 2'd1}) begin
      failures++;
      $display("FAIL mismatch_halt got chk=%0b hcnt=%0d scnt=%0d exp 0 1 1", h_checking, h_count, s_count);
    end
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    checks++;
    if (d_err !== 1'b0 || d_count !== 8'd1) begin
      failures++;
      $display("FAIL mismatch_pulse got err=%0b cnt=%0d exp 0 1", d_err, d_count);
    end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, 4'd0, 4'h1);
      checks++;
      if (s_count !== S_EXP[k-1] || d_count !== 8'(1 + k) || d_err !== 1'b1) begin
        failures++;
        $display("FAIL sat_count k=%0d got s=%0d d=%0d err=%0b exp s=%0d d=%0d err=1",
                 k, s_count, d_count, d_err, S_EXP[k-1], 1 + k);
      end
      checks++;
      if ({s_fexp, s_fact, d_fexp, d_fact} !== {4'd9, 4'd10, 4'd9, 4'd10}) begin
        failures++;
        $display("FAIL sat_capture k=%0d got %0h exp 9a9a", k, {s_fexp, s_fact, d_fexp, d_fact});
      end
      checks++;
      if (h_count !== 8'd1 || h_err !== 1'b0 || h_checking !== 1'b0) begin
        failures++;
        $display("FAIL halt_frozen k=%0d got cnt=%0d err=%0b chk=%0b exp 1 0 0", k, h_count, h_err, h_checking);
      end
    end
  endtask

  task automatic test_clear_halt();
    clear = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    clear = 1'b0;
    checks++;
    if ({h_sticky, h_count, h_fexp, h_fact, h_checking, s_count, s_sticky, d_count, d_sticky} !== 29'd0) begin
      failures++;
      $display("FAIL clear_status got %0h exp 0",
               {h_sticky, h_count, h_fexp, h_fact, h_checking, s_count, s_sticky, d_count, d_sticky});
    end
    checks++;
    if (d_checking !== 1'b1) begin
      failures++;
      $display("FAIL clear_keeps_check got=%0b exp=1", d_checking);
    end
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    checks++;
    if (h_checking !== 1'b0) begin
      failures++;
      $display("FAIL halt_sync got=%0b exp=0", h_checking);
    end
    cyc(1'b1, 1'b0, 4'd0, 4'd0);
    checks++;
    if (h_checking !== 1'b1 || h_err !== 1'b0) begin
      failures++;
      $display("FAIL halt_recheck got chk=%0b err=%0b exp 1 0", h_checking, h_err);
    end
  endtask

  task automatic test_clear_same_edge();
    clear = 1'b1;
    cyc(1'b1, 1'b0, 4'd0, 4'h5);
    clear = 1'b0;
    checks++;
    if ({d_err, d_count, d_sticky, h_count, h_err} !== 19'd0 || h_checking !== 1'b1) begin
      failures++;
      $display("FAIL clear_wins got err=%0b cnt=%0d sticky=%0b hcnt=%0d hchk=%0b exp 0 0 0 0 1",
               d_err, d_count, d_sticky, h_count, h_checking);
    end
    cyc(1'b1, 1'b0, 4'd0, 4'd0);
    checks++;
    if (d_err !== 1'b0 || d_count !== 8'd0) begin
      failures++;
      $display("FAIL clear_after got err=%0b cnt=%0d exp 0 0", d_err, d_count);
    end
  endtask

  task automatic test_reset_mid_check();
    cyc(1'b1, 1'b0, 4'd0, 4'h1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d_err, d_sticky, d_count, d_fexp, d_fact, d_checking, h_sticky, h_count} !== 28'd0) begin
      failures++;
      $display("FAIL reset_async got %0h exp 0",
               {d_err, d_sticky, d_count, d_fexp, d_fact, d_checking, h_sticky, h_count});
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 4'd0, 4'h5);
    checks++;
    if (d_err !== 1'b0 || d_checking !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got err=%0b chk=%0b exp 0 0", d_err, d_checking);
    end
    cyc(1'b1, 1'b0, 4'd0, 4'h5);
    checks++;
    if (d_err !== 1'b0 || d_checking !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_sync got err=%0b chk=%0b exp 0 1", d_err, d_checking);
    end
    cyc(1'b1, 1'b0, 4'd0, 4'h5);
    checks++;
    if (d_err !== 1'b1 || d_count !== 8'd1) begin
      failures++;
      $display("FAIL post_reset_check got err=%0b cnt=%0d exp 1 1", d_err, d_count);
    end
  endtask

  task automatic test_disable();
    check_en = 1'b0;
    cyc(1'b1, 1'b0, 4'd0, 4'h3);
    checks++;
    if (d_checking !== 1'b0 || d_err !== 1'b0 || d_count !== 8'd1) begin
      failures++;
      $display("FAIL disable got chk=%0b err=%0b cnt=%0d exp 0 0 1", d_checking, d_err, d_count);
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_load_priority();
    test_mismatch();
    test_saturation();
    test_clear_halt();
    test_clear_same_edge();
    test_reset_mid_check();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Hardware scoreboard on the observing end of the 4-bit loadable counter's port set (`enable_i`, `load_i`, `data_i`, `count_o`).
- Samples the counter's control inputs and output every clock, predicts the next count and flags mismatches.
- Keeps a saturating error count and captures the first failing expected/actual pair.
- Sits beside the counter DUT in the Counter_Env_2 bench or in an FPGA self-test build.

Parameters:
- `WIDTH`, 4: counter data width.
- `ERR_CNT_W`, 8: width of the saturating mismatch counter.
- `HALT_ON_ERR`, 0: 1 = stop checking after the first mismatch until `clear_i`.

Ports:
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset; asynchronous, active-high.
- `check_en_i`  input  1  enables checking.
- `clear_i`  input  1  sync clear of error status and counters.
- `enable_i`  input  1  observed counter enable.
- `load_i`  input  1  observed counter load.
- `data_i`  input  WIDTH  observed counter load data.
- `count_o`  input  WIDTH  observed counter output (checker input, keeps the DUT port name).
- `err_o`  output  1  one-cycle pulse per mismatch.
- `err_sticky_o`  output  1  set on first mismatch, held until `clear_i`/reset.
- `err_count_o`  output  ERR_CNT_W  mismatch count, saturates at all-ones.
- `first_exp_o`  output  WIDTH  expected value of first mismatch.
- `first_act_o`  output  WIDTH  actual value of first mismatch.
- `checking_o`  output  1  high while FSM in CHECK.

Behaviour:
- Counter reference rule, decided, for a given cycle:
  - `load_i` has priority: next = `data_i`.
  - else `enable_i`: next = count + 1 mod 2^WIDTH, so 15 wraps to 0.
  - else hold.
- Every rising edge registers `prev_cnt<=count_o`, `prev_en<=enable_i`, `prev_ld<=load_i`, `prev_dat<=data_i`.
- Expected value is computed combinationally from the prev registers: `exp = prev_ld ? prev_dat : prev_en ? prev_cnt+1 : prev_cnt`.
- The model reseeds from the observed count every cycle, so one error never cascades.
- FSM states: IDLE, SYNC, CHECK, HALT.
  - IDLE -> SYNC when `check_en_i`=1.
  - SYNC -> CHECK unconditionally on the next edge. Prev registers are valid after SYNC; no compare occurs in SYNC.
  - CHECK: compare `count_o` vs `exp` at each edge.
    - On mismatch with `HALT_ON_ERR`=1 -> HALT; otherwise stay in CHECK.
  - Any state -> IDLE at an edge where `check_en_i`=0. No compare occurs at that edge. Re-enabling always passes through SYNC.
  - HALT -> IDLE on `clear_i`.
- On a mismatch detected at edge k:
  - `err_o`=1 for the cycle after edge k.
  - `err_count_o` increments unless it is already all-ones.
  - If `err_sticky_o`=0: capture `first_exp_o`=exp and `first_act_o`=`count_o`, and set `err_sticky_o`.
  - Later mismatches never overwrite the capture.
- Error latency: the stimulus applied before edge k-1 is checked at edge k; `err_o` is visible one cycle after edge k.
- `clear_i`=1 at an edge:
  - zeroes `err_count_o`, `err_sticky_o`, `first_exp_o` and `first_act_o`;
  - suppresses any mismatch at that same edge (clear wins);
  - does not change the FSM except HALT -> IDLE.
- Reset: all outputs 0, FSM = IDLE, prev registers 0.
  - Reset asserted mid-check aborts immediately and asynchronously.
  - After release, SYNC is required before any compare.
- `checking_o` = (state==CHECK), registered state decode.

Decomposition:
- Package `counter_chk_pkg`: FSM state enum (IDLE, SYNC, CHECK, HALT), default `WIDTH`/`ERR_CNT_W` constants, and a `next_count` function implementing the reference rule.
- One sub-module is natural: `counter_ref_model`, which holds the prev registers and the combinational `exp` output.
- FSM, error counter and capture logic stay in `counter_checker`.

Test Plan:
- Correct counting: reset, `check_en_i`=1, `enable_i`=1 for 20 cycles with a correct DUT through the 15->0 wrap -> `err_o` never high, `err_count_o`=0, `checking_o`=1 from the 2nd edge after enable.
- Load priority: `load_i`=1 and `enable_i`=1 together with `data_i`=9, DUT outputs 9 -> no error.
- Same load, forced `count_o`=10 -> one `err_o` pulse, `first_exp_o`=9, `first_act_o`=10, `err_sticky_o`=1.
- Saturation: with `ERR_CNT_W`=2 inject 5 mismatches -> `err_count_o`=3; first capture unchanged after the 2nd error.
- `HALT_ON_ERR`=1: inject mismatch -> HALT, `checking_o`=0, further bad values not counted. Then `clear_i` -> all status 0, FSM=IDLE -> SYNC -> CHECK.
- Corner cases:
  - Mismatch on the same edge as `clear_i` -> `err_count_o` stays 0.
  - `rst_i` pulsed mid-CHECK between edges -> outputs 0 immediately, no compare on the first edge after release.
